// File: rtl/sr_latch_pkg.sv
// sr_latch_pkg: shared width default, {s,r} command encoding and its decoder
package sr_latch_pkg;
  localparam int DEF_WIDTH = 1;
  typedef enum logic [1:0] {
    HOLD    = 2'b00,
    RESET   = 2'b01,
    SET     = 2'b10,
    ILLEGAL = 2'b11
  } cmd_e;
  function automatic cmd_e decode_cmd(input logic s, input logic r);
    return cmd_e'({s, r});
  endfunction
endpackage

// File: rtl/sr_latch_cell.sv
// sr_latch_cell: one gated SR latch bit, reset-dominant, async active-low clear
//   clock   : transparent while high, opaque while low
//   reset_n : async clear, forces q=0 / qbar=1
//   s, r    : set / reset requests
//   q, qbar : stored state and its complement
//   illegal : s=r=1 seen while transparent
module sr_latch_cell
  import sr_latch_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic s,
  input  logic r,
  output logic q,
  output logic qbar,
  output logic illegal
);
  cmd_e w_cmd;
  logic w_set;
  logic w_rst;
  logic r_q;
  assign w_cmd = decode_cmd(s, r);
  // clock gates both inputs of the NOR pair; r wins when both are asserted
  assign w_set = clock && (w_cmd == SET);
  assign w_rst = clock && (w_cmd == RESET || w_cmd == ILLEGAL);
  always_latch begin
    if (!reset_n) r_q <= 1'b0;
    else if (w_rst) r_q <= 1'b0;
    else if (w_set) r_q <= 1'b1;
  end
  assign q       = r_q;
  assign qbar    = ~r_q;
  assign illegal = clock && reset_n && (w_cmd == ILLEGAL);
endmodule

// File: rtl/sr_latch_gates.sv
// sr_latch_gates: bank of WIDTH independent gated SR latches
//   clock   : latch enable, transparent while high
//   reset_n : async active-low clear of every bit
//   s, r    : per-bit set / reset requests
//   q, qbar : per-bit state and complement
//   illegal : per-bit flag for s=r=1 while transparent
module sr_latch_gates
  import sr_latch_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter bit QBAR_CHECK = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] illegal
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_latch_cell u_cell (
      .clock   (clock),
      .reset_n (reset_n),
      .s       (s[i]),
      .r       (r[i]),
      .q       (q[i]),
      .qbar    (qbar[i]),
      .illegal (illegal[i])
    );
  end
  if (QBAR_CHECK) begin : g_chk
    always_comb assert (qbar == ~q);
  end
endmodule

// File: tb/tb_sr_latch_gates.sv
// tb_sr_latch_gates: directed plus randomized checks of the SR latch bank against a rule model
module tb_sr_latch_gates;
  localparam int W = 4;
  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] s       = '0;
  logic [W-1:0] r       = '0;
  logic [W-1:0] q, qbar, illegal;
  logic [W-1:0] m_q     = '0;
  int checks = 0;
  int errors = 0;

  sr_latch_gates #(.WIDTH(W), .QBAR_CHECK(1'b1)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .q       (q),
    .qbar    (qbar),
    .s       (s),
    .r       (r),
    .illegal (illegal)
  );

  task automatic cmp(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check(input string tag);
    logic [W-1:0] exp_ill;
    for (int b = 0; b < W; b++) begin
      if (!reset_n) m_q[b] = 1'b0;
      else if (clock && r[b]) m_q[b] = 1'b0;
      else if (clock && s[b]) m_q[b] = 1'b1;
    end
    exp_ill = (clock && reset_n) ? (s & r) : '0;
    cmp({tag, ".q"}, q, m_q);
    cmp({tag, ".qbar"}, qbar, ~m_q);
    cmp({tag, ".illegal"}, illegal, exp_ill);
  endtask

  task automatic step(input logic c, input logic rn, input logic [W-1:0] sv,
                      input logic [W-1:0] rv, input string tag);
    clock   = c;
    reset_n = rn;
    s       = sv;
    r       = rv;
    #1;
    check(tag);
  endtask

  initial begin
    for (int k = 0; k < 6; k++) step(~clock, 1'b0, 4'hF, 4'h0, "rst_toggle");
    step(1'b1, 1'b0, 4'hF, 4'h0, "rst_hi");
    step(1'b1, 1'b1, 4'hF, 4'h0, "rst_release");
    cmp("rst_release_const", q, 4'hF);
    step(1'b1, 1'b1, 4'h0, 4'hF, "t2_reset");
    cmp("t2_reset_const", q, 4'h0);
    step(1'b1, 1'b1, 4'h0, 4'h0, "t2_hold0");
    step(1'b1, 1'b1, 4'hF, 4'h0, "t2_set");
    cmp("t2_set_const", qbar, 4'h0);
    step(1'b1, 1'b1, 4'h0, 4'h0, "t2_hold1");
    cmp("t2_hold1_const", q, 4'hF);
    step(1'b1, 1'b1, 4'hF, 4'hF, "t3_both");
    cmp("t3_both_ill", illegal, 4'hF);
    cmp("t3_both_q", q, 4'h0);
    step(1'b1, 1'b1, 4'h0, 4'h0, "t3_leave");
    cmp("t3_leave_q", q, 4'h0);
    step(1'b0, 1'b1, 4'h0, 4'h0, "t4_low");
    step(1'b0, 1'b1, 4'hF, 4'h0, "t4_s_opaque");
    cmp("t4_s_opaque_const", q, 4'h0);
    step(1'b1, 1'b1, 4'hF, 4'h0, "t4_rise");
    cmp("t4_rise_const", q, 4'hF);
    step(1'b0, 1'b1, 4'hF, 4'h0, "t5_fall");
    step(1'b0, 1'b1, 4'h0, 4'hF, "t5_r_opaque");
    cmp("t5_r_opaque_const", q, 4'hF);
    step(1'b1, 1'b1, 4'h0, 4'hF, "t5_rise");
    cmp("t5_rise_const", q, 4'h0);
    step(1'b1, 1'b1, 4'b1010, 4'b0110, "t6_mix");
    cmp("t6_mix_q", q, 4'b1000);
    cmp("t6_mix_qbar", qbar, 4'b0111);
    cmp("t6_mix_ill", illegal, 4'b0010);
    step(1'b1, 1'b0, 4'b1010, 4'b0110, "t6_rst");
    cmp("t6_rst_const", q, 4'b0000);
    // only one of clock, reset_n or the s/r pair changes per step
    for (int k = 0; k < 400; k++) begin
      int act;
      act = $urandom_range(0, 9);
      if (act == 0) step(clock, ~reset_n, s, r, "rnd_rst");
      else if (act < 5) step(~clock, reset_n, s, r, "rnd_clk");
      else step(clock, reset_n, W'($urandom), W'($urandom), "rnd_sr");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
